load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum BUS-state cycles without mem_ack.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  execute-stage access request.
REQ-007 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  DATA_WIDTH  byte address.
REQ-010 req_wdata  in  DATA_WIDTH  store data, right-aligned.
REQ-011 req_type  in  3  memAccessType_t (BYTE, HALF, WORD, BYTE_U, HALF_U).
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  DATA_WIDTH  formatted load data, 0 for stores and errors.
REQ-014 rsp_err  out  1  misaligned, illegal type or timeout, valid with rsp_valid.
REQ-015 mem_req / mem_we  out  1 each  bus request and write strobe.
REQ-016 mem_addr  out  DATA_WIDTH  word-aligned address, {addr[31:2],2'b00}.
REQ-017 mem_wdata  out  DATA_WIDTH;  mem_be  out  4  lane-replicated data and byte enables.
REQ-018 mem_ack  in  1;  mem_rdata  in  DATA_WIDTH  bus completion and read word.

Function
REQ-019 SHALL implement FSM IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-020 IDLE, accepted legal aligned request SHALL latch all request fields and move to BUS next cycle.
REQ-021 IDLE, accepted request that is misaligned (HALF/HALF_U with addr[0]=1, WORD with addr[1:0]!=0) or has req_type 5-7 SHALL go straight to RESP with rsp_err=1, no bus activity.
REQ-022 BUS: mem_req=1 with mem_addr/mem_we/mem_wdata/mem_be stable until mem_ack; on mem_ack SHALL capture mem_rdata and move to RESP.
REQ-023 BUS: timeout counter SHALL clear on BUS entry and increment each cycle without ack; on reaching TIMEOUT_CYCLES SHALL drop mem_req, move to RESP with rsp_err=1.
REQ-024 mem_ack in the same cycle as the timeout SHALL win (success, no error).
REQ-025 RESP: rsp_valid=1 for exactly one cycle, then IDLE; no response backpressure.
REQ-026 Minimum latency: accept cycle N, mem_req cycle N+1, ack N+1 -> rsp_valid N+2; error-path rsp_valid N+1.
REQ-027 mem_be: BYTE 4'b0001<<addr[1:0], HALF 4'b0011<<addr[1:0], WORD 4'b1111; loads drive same mask.
REQ-028 mem_wdata: byte replicated to all 4 lanes, half to both halves, word as is.
REQ-029 Load format: select lane by addr[1:0]; BYTE/HALF sign-extend, BYTE_U/HALF_U zero-extend, WORD pass-through.
REQ-030 mem_ack outside BUS SHALL be ignored.

Reset
REQ-031 rst SHALL force IDLE, counter 0, latched fields 0; outputs req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-032 rst mid-BUS SHALL drop mem_req next edge and suppress any response.

Structure
REQ-033 lsu_state_t and LSU_TIMEOUT_DEFAULT SHALL live in the shared riscv_definitions package beside memAccessType_t.
REQ-034 Load formatting SHALL be a combinational sub-module lsu_load_align.

Verification
REQ-035 LW addr 0x100, mem_rdata 0xDEADBEEF, ack after 2 cycles -> rsp_rdata 0xDEADBEEF, err 0, mem_be 1111.
REQ-036 LB addr 0x103, mem_rdata 0x80FF_0000 -> rsp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH addr 0x202, wdata 0x1234ABCD -> mem_addr 0x200, mem_be 1100, mem_wdata 0xABCDABCD, rsp_err 0.
REQ-038 LW addr 0x101 -> no mem_req, rsp_valid next cycle, rsp_err 1, rsp_rdata 0.
REQ-039 LW with mem_ack never asserted -> mem_req high 16 cycles, then rsp_err 1; ack on cycle 16 -> err 0.
REQ-040 rst asserted during BUS -> mem_req 0 and req_ready 1 next cycle, no rsp_valid.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared RISC-V definitions: access types, LSU state encoding and LSU helpers.
package riscv_definitions;

    typedef enum logic [2:0] {
        BYTE   = 3'd0,
        HALF   = 3'd1,
        WORD   = 3'd2,
        BYTE_U = 3'd3,
        HALF_U = 3'd4
    } memAccessType_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    localparam int LSU_TIMEOUT_DEFAULT = 16;

    // Codes 5-7 are not access types and are rejected like a misaligned access.
    function automatic logic lsu_req_bad(input logic [2:0] t, input logic [1:0] a);
        case (t)
            BYTE, BYTE_U: lsu_req_bad = 1'b0;
            HALF, HALF_U: lsu_req_bad = a[0];
            WORD:         lsu_req_bad = (a != 2'b00);
            default:      lsu_req_bad = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lsu_byte_en(input logic [2:0] t, input logic [1:0] a);
        case (t)
            BYTE, BYTE_U: lsu_byte_en = 4'b0001 << a;
            HALF, HALF_U: lsu_byte_en = 4'b0011 << a;
            default:      lsu_byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module lsu_load_align
    import riscv_definitions::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [2:0]            type_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[8*addr_lo_i +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (type_i)
            BYTE:    data_o = {{24{byte_sel[7]}}, byte_sel};
            BYTE_U:  data_o = {24'd0, byte_sel};
            HALF:    data_o = {{16{half_sel[15]}}, half_sel};
            HALF_U:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: request latch, bus handshake with timeout,
// one-cycle response pulse.
//
// state    | meaning
// IDLE     | ready for a request
// BUS      | mem_req held until mem_ack or timeout
// RESP     | rsp_valid pulse, then back to IDLE
module load_store_unit
    import riscv_definitions::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [2:0]            req_type,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t            state_q, state_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            type_q, type_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] load_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            type_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            type_q  <= type_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        type_d  = type_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    type_d  = req_type;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = lsu_req_bad(req_type, req_addr[1:0]);
                    state_d = err_d ? LSU_RESP : LSU_BUS;
                end
            end
            LSU_BUS: begin
                // An ack arriving on the last allowed cycle still counts as success.
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = LSU_RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = LSU_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .rdata_i   (rdata_q),
        .addr_lo_i (addr_q[1:0]),
        .type_i    (type_q),
        .data_o    (load_data)
    );

    always_comb begin
        req_ready = (state_q == LSU_IDLE);
        rsp_valid = (state_q == LSU_RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !we_q && !err_q) ? load_data : '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        if (state_q == LSU_BUS) begin
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
            mem_be   = lsu_byte_en(type_q, addr_q[1:0]);
            case (type_q)
                BYTE, BYTE_U: mem_wdata = {4{wdata_q[7:0]}};
                HALF, HALF_U: mem_wdata = {2{wdata_q[15:0]}};
                default:      mem_wdata = wdata_q;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: table-driven accesses, timeout, reset and stray-ack cases.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_type;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          ack_at;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cycles;
    } txn_t;

    rsp_t sb[$];
    txn_t tq[$];

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_type  (req_type),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h want=0x%08h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest pending expectation.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("rsp_rdata", rsp_rdata, e.rdata);
                    check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic run_txn(input txn_t t);
        int cyc;
        @(negedge clk);
        check_eq("req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = t.we;
        req_addr  = t.addr;
        req_wdata = t.wdata;
        req_type  = t.typ;
        sb.push_back('{rdata: t.exp_rdata, err: t.exp_err});
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        @(negedge clk);
        for (int i = 0; i < 40 && mem_req; i++) begin
            cyc++;
            check_eq("mem_addr", mem_addr, t.exp_addr);
            check_eq("mem_be", {28'd0, mem_be}, {28'd0, t.exp_be});
            check_eq("mem_wdata", mem_wdata, t.exp_wdata);
            check_eq("mem_we", {31'd0, mem_we}, {31'd0, t.we});
            if (cyc == t.ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = t.rd;
            end
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            @(negedge clk);
        end
        check_eq("bus_cycles", cyc, t.exp_cycles);
        check_eq("rsp_latency", {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_type = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);

        // we typ addr wdata rd ack_at exp_addr exp_be exp_wdata exp_rdata exp_err exp_cycles
        tq.push_back('{1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 3, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 3});
        tq.push_back('{1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 1, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 1});
        tq.push_back('{1'b0, 3'd3, 32'h103, 32'h0, 32'h80FF0000, 1, 32'h100, 4'b1000, 32'h0, 32'h00000080, 1'b0, 1});
        tq.push_back('{1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h55555555, 1, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 1});
        tq.push_back('{1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0});
        tq.push_back('{1'b0, 3'd2, 32'h300, 32'h0, 32'h0, 0, 32'h300, 4'b1111, 32'h0, 32'h0, 1'b1, 16});
        tq.push_back('{1'b0, 3'd2, 32'h304, 32'h0, 32'hCAFEF00D, 16, 32'h304, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, 16});
        tq.push_back('{1'b0, 3'd1, 32'h402, 32'h0, 32'h80011234, 2, 32'h400, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 2});
        tq.push_back('{1'b0, 3'd4, 32'h400, 32'h0, 32'h8001F234, 1, 32'h400, 4'b0011, 32'h0, 32'h0000F234, 1'b0, 1});
        tq.push_back('{1'b1, 3'd0, 32'h501, 32'h000000A5, 32'h0, 1, 32'h500, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0, 1});
        tq.push_back('{1'b1, 3'd2, 32'h600, 32'h11223344, 32'h0, 4, 32'h600, 4'b1111, 32'h11223344, 32'h0, 1'b0, 4});
        tq.push_back('{1'b0, 3'd5, 32'h700, 32'h0, 32'h0, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0});
        tq.push_back('{1'b0, 3'd4, 32'h401, 32'h0, 32'h0, 1, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0});
        tq.push_back('{1'b0, 3'd0, 32'h101, 32'h0, 32'h00007F00, 1, 32'h100, 4'b0010, 32'h0, 32'h0000007F, 1'b0, 1});

        foreach (tq[i]) run_txn(tq[i]);

        // Stray ack while idle must not start or complete anything.
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        repeat (3) @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check_eq("stray_ack_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("stray_ack_ready", {31'd0, req_ready}, 32'd1);

        // Reset in the middle of a bus cycle: no response may follow.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h800; req_type = 3'd2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check_eq("rstbus_mem_req_before", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rstbus_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rstbus_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rstbus_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (4) @(negedge clk);

        // Back-to-back check that the unit still works after reset.
        run_txn('{1'b0, 3'd2, 32'h900, 32'h0, 32'h0BADF00D, 1, 32'h900, 4'b1111, 32'h0, 32'h0BADF00D, 1'b0, 1});
        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
